// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg                                                                  |
// | Shared types, field positions and CRC helpers for the ALU serial link.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  localparam int c_FLAG_CARRY = 3;
  localparam int c_FLAG_OVFL  = 2;
  localparam int c_FLAG_ZERO  = 1;
  localparam int c_FLAG_NEG   = 0;

  // Error byte carries each flag twice: upper copy here, lower copy 3 bits down.
  localparam int c_ERR_D = 6;
  localparam int c_ERR_C = 5;
  localparam int c_ERR_O = 4;

  localparam logic c_FT_CTL  = 1'b1;
  localparam logic c_FT_DATA = 1'b0;

  function automatic logic [3:0] crc4(input logic [67:0] v);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ v[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  function automatic logic [2:0] crc3(input logic [36:0] v);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ v[i];
      c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return c;
  endfunction

  function automatic logic [10:0] mk_frame(input logic t, input logic [7:0] d);
    return {1'b0, t, d, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_frame_rx                                                             |
// | Bit-level START/TYPE/DATA/STOP deserialiser for one 11-bit frame.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_frame_rx (
  input  logic       clk,
  input  logic       RST,
  input  logic       i_en,
  input  logic       i_sin,
  output logic       o_frame_valid,
  output logic       o_frame_type,
  output logic [7:0] o_frame_data,
  output logic       o_frame_stop_err
);
  import alu_pkg::*;

  logic       r_active;
  logic [3:0] r_cnt;
  logic       r_type;
  logic [7:0] r_data;

  always_ff @(posedge clk) begin
    if (RST || !i_en) begin
      r_active <= 1'b0;
      r_cnt    <= 4'd0;
      r_type   <= c_FT_DATA;
      r_data   <= 8'd0;
    end else if (!r_active) begin
      if (!i_sin) begin
        r_active <= 1'b1;
        r_cnt    <= 4'd1;
      end
    end else begin
      if (r_cnt == 4'd1)
        r_type <= i_sin;
      else if (r_cnt <= 4'd9)
        r_data <= {r_data[6:0], i_sin};
      if (r_cnt == 4'd10) begin
        r_active <= 1'b0;
        r_cnt    <= 4'd0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Valid while the STOP bit is on the pin so the consumer latches it on the same edge.
  assign o_frame_valid    = r_active && (r_cnt == 4'd10);
  assign o_frame_type     = r_type;
  assign o_frame_data     = r_data;
  assign o_frame_stop_err = ~i_sin;

endmodule
`default_nettype wire

// File: rtl/alu_serial_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_serial_responder                                                     |
// | Receives a 9-frame ALU request, checks it, executes, serialises reply.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_serial_responder #(
  parameter int RSP_GAP = 2,
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic RST,
  input  logic sin,
  output logic sout,
  output logic busy,
  output logic err
);
  import alu_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE, S_RX_FRAME, S_RX_GAP, S_EXEC, S_WAIT, S_TX
  } state_t;

  // A gap of 0 cannot be met after the EXEC cycle, so it behaves as 1.
  localparam logic [7:0]  c_WAIT_LAST = (RSP_GAP > 1) ? 8'(RSP_GAP - 1) : 8'd0;
  localparam logic [15:0] c_TO        = 16'(TIMEOUT);

  state_t      r_state;
  logic        r_sout, r_busy, r_err;
  logic [3:0]  r_fcnt;
  logic [63:0] r_ba;
  logic [6:0]  r_ctl;
  logic        r_derr;
  logic [15:0] r_gap;
  logic [7:0]  r_wcnt;
  logic [54:0] r_tx;
  logic [5:0]  r_txleft;
  logic        r_is_err;

  logic        w_rx_en, w_fvalid, w_ftype, w_fstop_err, w_last;
  logic [7:0]  w_fdata;
  logic [31:0] w_b, w_a, w_c;
  logic [32:0] w_sum, w_dif;
  logic        w_carry, w_ovfl, w_op_ok, w_crc_ok;
  logic        w_ed, w_ec, w_eo, w_is_err;
  logic [3:0]  w_flags;
  logic [7:0]  w_err_byte, w_ok_ctl;
  logic [54:0] w_tx_ok;

  assign w_rx_en = (r_state == S_IDLE) || (r_state == S_RX_FRAME) || (r_state == S_RX_GAP);

  alu_frame_rx u_rx (
    .clk              (clk),
    .RST              (RST),
    .i_en             (w_rx_en),
    .i_sin            (sin),
    .o_frame_valid    (w_fvalid),
    .o_frame_type     (w_ftype),
    .o_frame_data     (w_fdata),
    .o_frame_stop_err (w_fstop_err)
  );

  assign w_last = (r_fcnt == 4'd8);
  assign w_b    = r_ba[63:32];
  assign w_a    = r_ba[31:0];
  assign w_sum  = {1'b0, w_b} + {1'b0, w_a};
  assign w_dif  = {1'b0, w_b} - {1'b0, w_a};

  always_comb begin
    w_c     = 32'd0;
    w_carry = 1'b0;
    w_ovfl  = 1'b0;
    w_op_ok = 1'b1;
    case (r_ctl[6:4])
      OP_AND: w_c = w_b & w_a;
      OP_OR:  w_c = w_b | w_a;
      OP_ADD: begin
        w_c     = w_sum[31:0];
        w_carry = w_sum[32];
        w_ovfl  = (w_b[31] == w_a[31]) && (w_c[31] != w_b[31]);
      end
      OP_SUB: begin
        w_c     = w_dif[31:0];
        w_carry = w_dif[32];
        w_ovfl  = (w_b[31] != w_a[31]) && (w_c[31] != w_b[31]);
      end
      default: w_op_ok = 1'b0;
    endcase

    w_flags              = 4'd0;
    w_flags[c_FLAG_CARRY] = w_carry;
    w_flags[c_FLAG_OVFL]  = w_ovfl;
    w_flags[c_FLAG_ZERO]  = (w_c == 32'd0);
    w_flags[c_FLAG_NEG]   = w_c[31];

    w_crc_ok = (crc4({w_b, w_a, 1'b1, r_ctl[6:4]}) == r_ctl[3:0]);
    w_ed     = r_derr;
    w_ec     = !w_ed && !w_crc_ok;
    w_eo     = !w_ed && !w_ec && !w_op_ok;
    w_is_err = w_ed || w_ec || w_eo;

    w_err_byte              = 8'h80;
    w_err_byte[c_ERR_D]     = w_ed;
    w_err_byte[c_ERR_C]     = w_ec;
    w_err_byte[c_ERR_O]     = w_eo;
    w_err_byte[c_ERR_D - 3] = w_ed;
    w_err_byte[c_ERR_C - 3] = w_ec;
    w_err_byte[c_ERR_O - 3] = w_eo;
    w_err_byte[0]           = ^w_err_byte[7:1];

    w_ok_ctl = {1'b0, w_flags, crc3({w_c, 1'b0, w_flags})};
    w_tx_ok  = {mk_frame(c_FT_DATA, w_c[31:24]), mk_frame(c_FT_DATA, w_c[23:16]),
                mk_frame(c_FT_DATA, w_c[15:8]),  mk_frame(c_FT_DATA, w_c[7:0]),
                mk_frame(c_FT_CTL, w_ok_ctl)};
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_sout   <= 1'b1;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_fcnt   <= 4'd0;
      r_ba     <= 64'd0;
      r_ctl    <= 7'd0;
      r_derr   <= 1'b0;
      r_gap    <= 16'd0;
      r_wcnt   <= 8'd0;
      r_tx     <= 55'd0;
      r_txleft <= 6'd0;
      r_is_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sout <= 1'b1;
          r_fcnt <= 4'd0;
          r_derr <= 1'b0;
          if (!sin) begin
            r_state <= S_RX_FRAME;
            r_busy  <= 1'b1;
          end
        end
        S_RX_FRAME: begin
          if (w_fvalid) begin
            r_derr <= r_derr || w_fstop_err ||
                      (w_last ? (w_ftype != c_FT_CTL) : (w_ftype != c_FT_DATA));
            if (w_last) begin
              r_ctl   <= w_fdata[6:0];
              r_state <= S_EXEC;
            end else begin
              r_ba    <= {r_ba[55:0], w_fdata};
              r_fcnt  <= r_fcnt + 4'd1;
              r_gap   <= 16'd0;
              r_state <= S_RX_GAP;
            end
          end
        end
        S_RX_GAP: begin
          if (!sin) begin
            r_state <= S_RX_FRAME;
          end else if ((TIMEOUT != 0) && (r_gap == c_TO)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_fcnt  <= 4'd0;
          end else begin
            r_gap <= r_gap + 16'd1;
          end
        end
        S_EXEC: begin
          r_tx     <= w_is_err ? {mk_frame(c_FT_CTL, w_err_byte), 44'd0} : w_tx_ok;
          r_is_err <= w_is_err;
          r_wcnt   <= 8'd0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wcnt == c_WAIT_LAST) begin
            r_sout   <= r_tx[54];
            r_tx     <= {r_tx[53:0], 1'b0};
            r_txleft <= r_is_err ? 6'd10 : 6'd54;
            r_err    <= r_is_err;
            r_state  <= S_TX;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        S_TX: begin
          r_sout   <= r_tx[54];
          r_tx     <= {r_tx[53:0], 1'b0};
          r_txleft <= r_txleft - 6'd1;
          if (r_txleft == 6'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sout = r_sout;
  assign busy = r_busy;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_serial_responder                                                  |
// | Directed self-checking bench for the ALU serial responder.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_serial_responder;
  import alu_pkg::*;

  localparam int P_GAP = 2;
  localparam int P_TO  = 20;

  logic clk = 1'b0;
  logic RST, sin, sout, busy, err;
  int   n_cmp = 0;
  int   n_mis = 0;

  alu_serial_responder #(.RSP_GAP(P_GAP), .TIMEOUT(P_TO)) dut (
    .clk  (clk),
    .RST  (RST),
    .sin  (sin),
    .sout (sout),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // CRC as remainder of M(x)*x^n mod P(x) by long division.
  function automatic logic [3:0] ref_crc4(input logic [67:0] m);
    logic [71:0] v;
    v = {m, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
    return v[3:0];
  endfunction

  function automatic logic [2:0] ref_crc3(input logic [36:0] m);
    logic [39:0] v;
    v = {m, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
    return v[2:0];
  endfunction

  function automatic logic [39:0] ok_exp(input logic [31:0] c, input logic [3:0] f);
    return {c, 1'b0, f, ref_crc3({c, 1'b0, f})};
  endfunction

  task automatic drive_frame(input logic t, input logic [7:0] d);
    logic [10:0] f;
    f = {1'b0, t, d, 1'b1};
    for (int i = 10; i >= 0; i--) begin
      @(negedge clk);
      sin = f[i];
    end
  endtask

  task automatic send_frames(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                             input logic marker, input int ctl_at, input int lo, input int hi);
    logic [71:0] fb;
    fb = {b, a, 1'b0, op, ref_crc4({b, a, marker, op})};
    for (int i = lo; i <= hi; i++)
      drive_frame((i == 8) != (i == ctl_at), fb[8*(8-i) +: 8]);
  endtask

  task automatic recv_frame(output int lat, output logic [9:0] body, output logic e0);
    lat  = 0;
    body = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (sout === 1'b0) break;
    end
    e0 = err;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      body = {body[8:0], sout};
    end
  endtask

  task automatic expect_rsp(input string tag, input int nf, input logic [39:0] want);
    int         lat;
    logic [9:0] body;
    logic       e0;
    for (int f = 0; f < nf; f++) begin
      recv_frame(lat, body, e0);
      check({tag, " lat"}, 64'(lat), (f == 0) ? 64'(P_GAP + 2) : 64'd1);
      check({tag, " frame"}, 64'(body), 64'({(f == nf - 1), want[8*(nf-1-f) +: 8], 1'b1}));
      if (f == 0) check({tag, " err"}, 64'(e0), 64'(nf == 1));
    end
    @(negedge clk);
    check({tag, " idle"}, 64'({busy, err, sout}), 64'd1);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sout !== 1'b1 || err !== 1'b0) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    RST = 1'b1;
    sin = 1'b1;
    repeat (3) @(negedge clk);
    check("reset", 64'({busy, err, sout}), 64'd1);
    RST = 1'b0;
    repeat (2) @(negedge clk);

    // ADD wrapping to zero with carry
    send_frames(32'hFFFF_FFFF, 32'h1, OP_ADD, 1'b1, -1, 0, 8);
    check("T1 busy", 64'(busy), 64'd1);
    expect_rsp("T1 add", 5, ok_exp(32'h0, 4'b1010));

    send_frames(32'h8000_0000, 32'h1, OP_SUB, 1'b1, -1, 0, 8);
    expect_rsp("T2 sub ovfl", 5, ok_exp(32'h7FFF_FFFF, 4'b0100));
    send_frames(32'h0, 32'h1, OP_SUB, 1'b1, -1, 0, 8);
    expect_rsp("T2 sub borrow", 5, ok_exp(32'hFFFF_FFFF, 4'b1001));

    // CRC taken over a 0 marker bit
    send_frames(32'hF0F0_F0F0, 32'h0F0F_0F0F, OP_AND, 1'b0, -1, 0, 8);
    expect_rsp("T3 crc err", 1, 40'hA5);

    send_frames(32'h1234_5678, 32'h9ABC_DEF0, 3'b010, 1'b1, -1, 0, 8);
    expect_rsp("T4 bad op", 1, 40'h93);
    send_frames(32'h1234_5678, 32'h1, OP_ADD, 1'b1, 3, 0, 8);
    expect_rsp("T4 ctl in data", 1, 40'hC9);

    // Reset during frame 5
    send_frames(32'hDEAD_BEEF, 32'hCAFE_F00D, OP_ADD, 1'b1, -1, 0, 4);
    @(negedge clk); sin = 1'b0;
    @(negedge clk); sin = 1'b0;
    @(negedge clk); sin = 1'b1;
    @(negedge clk); RST = 1'b1; sin = 1'b1;
    @(negedge clk);
    check("T5 reset state", 64'({busy, err, sout}), 64'd1);
    RST = 1'b0;
    expect_quiet("T5 no rsp", 60);
    send_frames(32'h0, 32'h0, OP_OR, 1'b1, -1, 0, 8);
    expect_rsp("T5 or", 5, ok_exp(32'h0, 4'b0010));

    // Gap of exactly TIMEOUT idle cycles is still accepted
    send_frames(32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 1'b1, -1, 0, 3);
    repeat (P_TO) @(negedge clk);
    send_frames(32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 1'b1, -1, 4, 8);
    expect_rsp("T6 gap edge", 5, ok_exp(32'hF000_F000, 4'b0001));

    // Stall longer than TIMEOUT drops the partial request
    send_frames(32'h1111_1111, 32'h2222_2222, OP_ADD, 1'b1, -1, 0, 2);
    expect_quiet("T6 stall", 30);
    check("T6 busy drop", 64'(busy), 64'd0);
    send_frames(32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b1, -1, 0, 8);
    expect_rsp("T6 after stall", 5, ok_exp(32'h8000_0000, 4'b0101));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
